etapa_decodificacion: RTL

ETAPA_DECODIFICACION -- requirements
Module: etapa_decodificacion

---
 rtl/etapa_decodificacion_if.sv | 45 ++++
 rtl/etapa_decodificacion.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/etapa_decodificacion_if.sv
// Decode-stage bus: groups the fetch-side inputs, the EX-stage hazard
// inputs, the register-file address outputs and the registered decode
// results of etapa_decodificacion into one bundle.
//
// Handshake: Instr_In is offered whenever In_Valid=1. The stage takes it
// on a rising edge unless Stall=1 in that cycle. While Stall=1 the
// upstream keeps Instr_In and In_Valid unchanged. Flush overrides Stall.
// Out_Valid=1 marks a real decoded instruction on the result signals.
// Out_Valid=0 marks a bubble, and the results then carry NOP controls.
//
//   master : fetch/testbench side (drives Instr_In .. Ex_MemRead)
//   slave  : the decode stage     (drives Add_A .. Illegal)
interface etapa_decodificacion_if;
  logic [31:0] Instr_In;
  logic        In_Valid;
  logic        Flush;
  logic [4:0]  Ex_Rd;
  logic        Ex_MemRead;
  logic [4:0]  Add_A;
  logic [4:0]  Add_B;
  logic        Stall;
  logic        Out_Valid;
  logic [4:0]  Rd_Out;
  logic [31:0] Imm_Out;
  logic [3:0]  Alu_Op;
  logic        Alu_Src;
  logic        Reg_Write;
  logic        Mem_Read;
  logic        Mem_Write;
  logic        Branch;
  logic        Jump;
  logic        Illegal;

  modport master (
    output Instr_In, In_Valid, Flush, Ex_Rd, Ex_MemRead,
    input  Add_A, Add_B, Stall, Out_Valid, Rd_Out, Imm_Out, Alu_Op,
           Alu_Src, Reg_Write, Mem_Read, Mem_Write, Branch, Jump, Illegal
  );

  modport slave (
    input  Instr_In, In_Valid, Flush, Ex_Rd, Ex_MemRead,
    output Add_A, Add_B, Stall, Out_Valid, Rd_Out, Imm_Out, Alu_Op,
           Alu_Src, Reg_Write, Mem_Read, Mem_Write, Branch, Jump, Illegal
  );
endinterface

// File: rtl/etapa_decodificacion.sv
// RV32I decode stage with load-use hazard stall.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      synchronous, active-low reset
//   bus        etapa_decodificacion_if.slave (see interface for the handshake)
//   fsm_state  debug view of the hazard FSM (0 = RUN, 1 = HOLD)
//
// Behaviour summary:
//   - Add_A/Add_B are combinational from Instr_In. They are zeroed where the
//     format has no such source register.
//   - A load in EX whose rd matches a used source register causes one bubble.
//     Stall is high in RUN. The FSM then spends one cycle in HOLD, where the
//     held instruction is accepted.
//   - Flush wins over everything and produces a bubble next cycle.
//   - Illegal opcodes decode as NOP_INSTR. With DECODE_ILLEGAL_TRAP_EN
//     defined they also raise Illegal; without it, Illegal is always 0.
//
// Alu_Op encoding: {funct7[5], funct3} for OP; for OP-IMM the same, with
// funct7[5] only taken for the shift-right group. BRANCH uses 4'b1000
// (subtract for compare). Everything else uses 4'b0000 (add). LUI relies on
// Add_A=0, so the result is x0 + imm.
module etapa_decodificacion #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  etapa_decodificacion_if.slave        bus,
  output logic                         fsm_state
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } dec_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  function automatic dec_t decode_word(input logic [31:0] i);
    dec_t d;
    d = '0;
    case (i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d.rd = i[11:7]; d.imm = {i[31:12], 12'b0};
        d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        d.rd = i[11:7];
        d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.alu_src = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1;
      end
      OPC_JALR: begin
        d.rd = i[11:7]; d.imm = {{20{i[31]}}, i[31:20]};
        d.alu_src = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1;
      end
      OPC_BRANCH: begin
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        d.alu_op = 4'b1000; d.branch = 1'b1;
      end
      OPC_LOAD: begin
        d.rd = i[11:7]; d.imm = {{20{i[31]}}, i[31:20]};
        d.alu_src = 1'b1; d.reg_write = 1'b1; d.mem_read = 1'b1;
      end
      OPC_STORE: begin
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        d.alu_src = 1'b1; d.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        d.rd = i[11:7]; d.imm = {{20{i[31]}}, i[31:20]};
        d.alu_op = {(i[14:12] == 3'b101) & i[30], i[14:12]};
        d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      OPC_OP: begin
        d.rd = i[11:7]; d.alu_op = {i[30], i[14:12]}; d.reg_write = 1'b1;
      end
      default: d = '0;
    endcase
    // x0 is never written.
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    return d;
  endfunction

  state_t     state, state_next;
  dec_t       raw_dec, nop_dec, in_dec, dec_q;
  logic [6:0] opcode;
  logic       in_legal, in_illegal, hazard, load_instr;
  logic       valid_q, illegal_q;

  assign opcode   = bus.Instr_In[6:0];
  assign raw_dec  = decode_word(bus.Instr_In);
  assign nop_dec  = decode_word(NOP_INSTR);
  assign in_legal = is_legal(opcode);
  assign in_dec   = in_legal ? raw_dec : nop_dec;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign in_illegal = ~in_legal;
`else
  assign in_illegal = 1'b0;
`endif

  // Register-file addresses; formats without rs1/rs2 present x0 so they can
  // never match a load destination.
  always_comb begin
    bus.Add_A = bus.Instr_In[19:15];
    bus.Add_B = bus.Instr_In[24:20];
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:     begin bus.Add_A = '0; bus.Add_B = '0; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:  bus.Add_B = '0;
      default:                         ;
    endcase
  end

  assign hazard = bus.In_Valid && bus.Ex_MemRead && (bus.Ex_Rd != 5'd0) &&
                  (((bus.Add_A != 5'd0) && (bus.Add_A == bus.Ex_Rd)) ||
                   ((bus.Add_B != 5'd0) && (bus.Add_B == bus.Ex_Rd)));

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= RUN;
    else        state <= state_next;
  end

  // FSM: next state. HOLD always lasts one cycle; detection is off in HOLD.
  always_comb begin
    state_next = RUN;
    if (!bus.Flush && (state == RUN) && hazard) state_next = HOLD;
  end

  // FSM: outputs
  always_comb begin
    bus.Stall  = RST_N && !bus.Flush && (state == RUN) && hazard;
    load_instr = !bus.Flush && !bus.Stall && bus.In_Valid;
  end

  assign fsm_state = state;

  // Output register: a decoded instruction or a NOP-control bubble.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      dec_q      <= nop_dec;
      dec_q.rd   <= '0;
      dec_q.imm  <= '0;
    end else if (load_instr) begin
      valid_q    <= 1'b1;
      illegal_q  <= in_illegal;
      dec_q      <= in_dec;
    end else begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      dec_q      <= nop_dec;
    end
  end

  assign bus.Out_Valid = valid_q;
  assign bus.Illegal   = illegal_q;
  assign bus.Rd_Out    = dec_q.rd;
  assign bus.Imm_Out   = dec_q.imm;
  assign bus.Alu_Op    = dec_q.alu_op;
  assign bus.Alu_Src   = dec_q.alu_src;
  assign bus.Reg_Write = dec_q.reg_write;
  assign bus.Mem_Read  = dec_q.mem_read;
  assign bus.Mem_Write = dec_q.mem_write;
  assign bus.Branch    = dec_q.branch;
  assign bus.Jump      = dec_q.jump;

endmodule
